// File: rtl/marquee_sequencer.sv
`timescale 1ns/1ps
// Run-control sequencer for the 8-digit ID marquee: owns the display frame,
// generates the shift tick and walks IDLE/RUN/PAUSE/FLASH from button pulses.
module marquee_sequencer #(
    parameter int               CLK_FREQ      = 100_000_000,
    parameter int               SHIFT_FREQ_HZ = 2,
    parameter int               WIDTH         = 64,
    parameter int               SHIFT_BITS    = 4,
    parameter logic [WIDTH-1:0] PATTERN_A     = 64'h2022_D185_0FAC_FBCF,
    parameter logic [WIDTH-1:0] PATTERN_B     = 64'h0123_4567_89AB_CDEF,
    parameter int               FLASH_TICKS   = 4
) (
    input  logic                                 sys_clk_in,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 pause,
    input  logic                                 stop,
    input  logic                                 direction,
    input  logic [1:0]                           speed_sel,
    input  logic                                 pattern_sel,
    input  logic                                 flash_en,
    output logic [WIDTH-1:0]                     frame_out,
    output logic                                 blank_out,
    output logic [1:0]                           state_out,
    output logic [$clog2(WIDTH/SHIFT_BITS)-1:0]  step_cnt,
    output logic [7:0]                           lap_cnt,
    output logic                                 busy
);

    localparam int STEPS       = WIDTH / SHIFT_BITS;
    localparam int STEP_W      = $clog2(STEPS);
    localparam int BASE_PERIOD = CLK_FREQ / SHIFT_FREQ_HZ;
    localparam int CNT_W       = $clog2(BASE_PERIOD + 1);
    localparam int FLASH_EDGES = 2 * FLASH_TICKS;
    localparam int FLASH_W     = $clog2(FLASH_EDGES + 1);

    localparam logic [CNT_W-1:0]   BASE_P     = CNT_W'(BASE_PERIOD);
    localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(STEPS - 1);
    localparam logic [FLASH_W-1:0] LAST_FLASH = FLASH_W'(FLASH_EDGES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_FLASH = 2'd3
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    tick_cnt_reg;
    logic [FLASH_W-1:0]  flash_cnt_reg;
    logic [WIDTH-1:0]    frame_reg;
    logic                blank_reg;
    logic [STEP_W-1:0]   step_reg;
    logic [7:0]          lap_reg;
    logic                busy_reg;

    logic [CNT_W-1:0]    period;
    logic [CNT_W-1:0]    period_m1;
    logic                counting;
    logic                tick;
    logic [WIDTH-1:0]    pattern_frame;
    logic [WIDTH-1:0]    rot_left;
    logic [WIDTH-1:0]    rot_right;

    // A zero period (very fast speed on a slow clock) degenerates to a tick every cycle.
    assign period    = BASE_P >> speed_sel;
    assign period_m1 = (period == '0) ? '0 : period - CNT_W'(1);
    assign counting  = (state_reg == S_RUN) || (state_reg == S_FLASH);
    // ">=" keeps a mid-count speed increase from overrunning the new period.
    assign tick      = counting && (tick_cnt_reg >= period_m1);

    assign pattern_frame = pattern_sel ? PATTERN_B : PATTERN_A;

    // Digit-wise rotation: each output digit picks its neighbour one position over.
    genvar gi;
    generate
        for (gi = 0; gi < STEPS; gi++) begin : g_digit
            assign rot_left[gi*SHIFT_BITS +: SHIFT_BITS] =
                frame_reg[((gi + STEPS - 1) % STEPS)*SHIFT_BITS +: SHIFT_BITS];
            assign rot_right[gi*SHIFT_BITS +: SHIFT_BITS] =
                frame_reg[((gi + 1) % STEPS)*SHIFT_BITS +: SHIFT_BITS];
        end
    endgenerate

    always_ff @(posedge sys_clk_in) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            tick_cnt_reg  <= '0;
            flash_cnt_reg <= '0;
            frame_reg     <= PATTERN_A;
            blank_reg     <= 1'b0;
            step_reg      <= '0;
            lap_reg       <= 8'd0;
            busy_reg      <= 1'b0;
        end else begin
            if (counting) begin
                tick_cnt_reg <= tick ? '0 : tick_cnt_reg + CNT_W'(1);
            end else if (state_reg == S_IDLE) begin
                tick_cnt_reg <= '0;
            end

            if (stop) begin
                state_reg    <= S_IDLE;
                frame_reg    <= pattern_frame;
                blank_reg    <= 1'b0;
                tick_cnt_reg <= '0;
                busy_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        frame_reg <= pattern_frame;
                        blank_reg <= 1'b0;
                        // pause outranks start even though it has no effect here
                        if (start && !pause) begin
                            state_reg <= S_RUN;
                            step_reg  <= '0;
                            busy_reg  <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (pause) begin
                            state_reg <= S_PAUSE;
                        end else if (tick) begin
                            frame_reg <= direction ? rot_right : rot_left;
                            if (step_reg == LAST_STEP) begin
                                step_reg <= '0;
                                lap_reg  <= lap_reg + 8'd1;
                                if (flash_en) begin
                                    state_reg     <= S_FLASH;
                                    flash_cnt_reg <= '0;
                                end
                            end else begin
                                step_reg <= step_reg + STEP_W'(1);
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (pause) begin
                            state_reg <= S_RUN;
                        end
                    end
                    S_FLASH: begin
                        if (tick) begin
                            if (flash_cnt_reg == LAST_FLASH) begin
                                blank_reg     <= 1'b0;
                                state_reg     <= S_RUN;
                                flash_cnt_reg <= '0;
                            end else begin
                                blank_reg     <= ~blank_reg;
                                flash_cnt_reg <= flash_cnt_reg + FLASH_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign frame_out = frame_reg;
    assign blank_out = blank_reg;
    assign state_out = state_reg;
    assign step_cnt  = step_reg;
    assign lap_cnt   = lap_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_marquee_sequencer.sv
`timescale 1ns/1ps
// Scoreboarded bench: a cycle-level reference model queues expected outputs,
// a monitor pops and compares them; directed checks pin the known frames.
module tb_marquee_sequencer;

    localparam int          CLKF  = 16;
    localparam int          SFH   = 2;
    localparam int          STEPS = 16;
    localparam int          FT    = 4;
    localparam logic [63:0] PAT_A = 64'h2022_D185_0FAC_FBCF;
    localparam logic [63:0] PAT_B = 64'h0123_4567_89AB_CDEF;

    logic        sys_clk_in;
    logic        reset;
    logic        start;
    logic        pause;
    logic        stop;
    logic        direction;
    logic [1:0]  speed_sel;
    logic        pattern_sel;
    logic        flash_en;
    logic [63:0] frame_out;
    logic        blank_out;
    logic [1:0]  state_out;
    logic [3:0]  step_cnt;
    logic [7:0]  lap_cnt;
    logic        busy;

    marquee_sequencer #(
        .CLK_FREQ      (CLKF),
        .SHIFT_FREQ_HZ (SFH),
        .WIDTH         (64),
        .SHIFT_BITS    (4),
        .PATTERN_A     (PAT_A),
        .PATTERN_B     (PAT_B),
        .FLASH_TICKS   (FT)
    ) dut (
        .sys_clk_in  (sys_clk_in),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .stop        (stop),
        .direction   (direction),
        .speed_sel   (speed_sel),
        .pattern_sel (pattern_sel),
        .flash_en    (flash_en),
        .frame_out   (frame_out),
        .blank_out   (blank_out),
        .state_out   (state_out),
        .step_cnt    (step_cnt),
        .lap_cnt     (lap_cnt),
        .busy        (busy)
    );

    initial sys_clk_in = 1'b0;
    always #5 sys_clk_in = ~sys_clk_in;

    typedef struct packed {
        logic [1:0]  st;
        logic [63:0] frame;
        logic        blank;
        logic [3:0]  step;
        logic [7:0]  lap;
        logic        busy;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state (0=IDLE 1=RUN 2=PAUSE 3=FLASH)
    int          m_state, m_step, m_lap, m_cnt, m_flashes;
    logic [63:0] m_frame;
    bit          m_blank;

    bit       nx_reset, nx_dir, nx_pat, nx_flash;
    bit [1:0] nx_speed;

    function automatic logic [63:0] rol4(input logic [63:0] f);
        return (f << 4) | (f >> 60);
    endfunction

    function automatic logic [63:0] ror4(input logic [63:0] f);
        return (f >> 4) | (f << 60);
    endfunction

    task automatic model_step();
        int   period;
        bit   tick;
        int   cnt_n;
        obs_t e;
        if (reset) begin
            m_state = 0; m_frame = PAT_A; m_blank = 0;
            m_step = 0; m_lap = 0; m_cnt = 0; m_flashes = 0;
        end else begin
            period = (CLKF / SFH) >> speed_sel;
            if (period < 1) period = 1;
            tick = (m_state == 1 || m_state == 3) && (m_cnt >= period - 1);
            if (m_state == 1 || m_state == 3) cnt_n = tick ? 0 : m_cnt + 1;
            else if (m_state == 2)            cnt_n = m_cnt;
            else                              cnt_n = 0;
            if (stop) begin
                m_state = 0; m_blank = 0; cnt_n = 0;
                m_frame = pattern_sel ? PAT_B : PAT_A;
            end else begin
                case (m_state)
                    0: begin
                        m_frame = pattern_sel ? PAT_B : PAT_A;
                        m_blank = 0;
                        if (start && !pause) begin m_state = 1; m_step = 0; end
                    end
                    1: begin
                        if (pause) m_state = 2;
                        else if (tick) begin
                            m_frame = direction ? ror4(m_frame) : rol4(m_frame);
                            m_step++;
                            if (m_step == STEPS) begin
                                m_step = 0;
                                m_lap  = (m_lap + 1) % 256;
                                if (flash_en) begin m_state = 3; m_flashes = 0; end
                            end
                        end
                    end
                    2: if (pause) m_state = 1;
                    default: begin
                        if (tick) begin
                            m_flashes++;
                            if (m_flashes == 2 * FT) begin m_blank = 0; m_state = 1; end
                            else m_blank = (m_flashes % 2) == 1;
                        end
                    end
                endcase
            end
            m_cnt = cnt_n;
        end
        e.st    = 2'(m_state);
        e.frame = m_frame;
        e.blank = m_blank;
        e.step  = 4'(m_step);
        e.lap   = 8'(m_lap);
        e.busy  = (m_state != 0);
        exp_q.push_back(e);
    endtask

    // Apply one cycle of stimulus at the falling edge and queue its expected result.
    task automatic drive(input bit st, input bit pa, input bit sp);
        @(negedge sys_clk_in);
        reset       = nx_reset;
        start       = st;
        pause       = pa;
        stop        = sp;
        direction   = nx_dir;
        speed_sel   = nx_speed;
        pattern_sel = nx_pat;
        flash_en    = nx_flash;
        model_step();
    endtask

    task automatic settle();
        @(posedge sys_clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("check %s ok value=%h", name, act);
        end
    endtask

    obs_t mon_exp, mon_got;
    int   mon_cycle = 0;
    always @(posedge sys_clk_in) begin
        #1;
        mon_cycle++;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {state_out, frame_out, blank_out, step_cnt, lap_cnt, busy};
            checks++;
            if (mon_got !== mon_exp) begin
                errors++;
                $display("FAIL cycle_%0d required st=%0d frame=%h blank=%0d step=%0d lap=%0d busy=%0d actual st=%0d frame=%h blank=%0d step=%0d lap=%0d busy=%0d",
                         mon_cycle, mon_exp.st, mon_exp.frame, mon_exp.blank, mon_exp.step, mon_exp.lap, mon_exp.busy,
                         mon_got.st, mon_got.frame, mon_got.blank, mon_got.step, mon_got.lap, mon_got.busy);
            end
        end
    end

    initial begin
        logic [63:0] exp_f;
        reset = 1'b1; start = 0; pause = 0; stop = 0;
        direction = 0; speed_sel = 0; pattern_sel = 0; flash_en = 0;
        nx_reset = 1; nx_dir = 0; nx_pat = 0; nx_flash = 1; nx_speed = 0;

        repeat (3) drive(0, 0, 0);
        settle();
        chk("reset_frame", frame_out, PAT_A);
        chk("reset_state", 64'(state_out), 0);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_step", 64'(step_cnt), 0);
        chk("reset_lap", 64'(lap_cnt), 0);

        nx_reset = 0;
        repeat (20) drive(0, 0, 0);
        settle();
        chk("idle_frame", frame_out, PAT_A);
        chk("idle_state", 64'(state_out), 0);
        chk("idle_blank", 64'(blank_out), 0);

        drive(1, 0, 0);
        repeat (7) drive(0, 0, 0);
        settle();
        chk("before_first_rotate", frame_out, PAT_A);
        drive(0, 0, 0);
        settle();
        chk("first_rotate_left", frame_out, 64'h022D_1850_FACF_BCF2);
        chk("first_step", 64'(step_cnt), 1);

        repeat (15 * 8) drive(0, 0, 0);
        settle();
        chk("lap_frame", frame_out, PAT_A);
        chk("lap_count", 64'(lap_cnt), 1);
        chk("lap_state_flash", 64'(state_out), 3);
        for (int i = 0; i < 2 * FT; i++) begin
            repeat (8) drive(0, 0, 0);
            settle();
            chk($sformatf("flash_blank_%0d", i), 64'(blank_out), (i % 2 == 0) ? 1 : 0);
            chk($sformatf("flash_state_%0d", i), 64'(state_out), (i == 2 * FT - 1) ? 1 : 3);
        end

        nx_flash = 0;
        drive(0, 0, 1);
        settle();
        chk("stop_state", 64'(state_out), 0);
        chk("stop_busy", 64'(busy), 0);
        nx_dir = 1;
        drive(1, 0, 0);
        repeat (8) drive(0, 0, 0);
        settle();
        chk("first_rotate_right", frame_out, 64'hF202_2D18_50FA_CFBC);

        repeat (3) drive(0, 0, 0);
        drive(0, 1, 0);
        repeat (50) drive(0, 0, 0);
        settle();
        chk("pause_state", 64'(state_out), 2);
        chk("pause_frame_frozen", frame_out, 64'hF202_2D18_50FA_CFBC);
        drive(0, 1, 0);
        repeat (3) drive(0, 0, 0);
        settle();
        chk("resume_no_rotate_yet", frame_out, 64'hF202_2D18_50FA_CFBC);
        drive(0, 0, 0);
        settle();
        chk("resume_rotate", frame_out, 64'hCF20_22D1_850F_ACFB);

        exp_f = 64'hCF20_22D1_850F_ACFB;
        nx_speed = 3;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0);
            settle();
            exp_f = ror4(exp_f);
            chk($sformatf("fast_rotate_%0d", i), frame_out, exp_f);
        end
        nx_speed = 0;
        repeat (7) drive(0, 0, 0);
        settle();
        chk("slow_again_hold", frame_out, exp_f);
        drive(0, 0, 0);
        settle();
        chk("slow_again_rotate", frame_out, ror4(exp_f));

        nx_speed = 3;
        drive(0, 0, 0);
        nx_pat = 1;
        drive(0, 0, 1);
        settle();
        chk("stop_tick_frame", frame_out, PAT_B);
        chk("stop_tick_state", 64'(state_out), 0);
        drive(1, 1, 0);
        settle();
        chk("pause_start_idle", 64'(state_out), 0);
        drive(1, 0, 0);
        drive(1, 1, 0);
        settle();
        chk("pause_start_run", 64'(state_out), 2);
        drive(0, 0, 1);

        nx_flash = 1;
        drive(1, 0, 0);
        repeat (16) drive(0, 0, 0);
        settle();
        chk("fast_lap_flash", 64'(state_out), 3);
        repeat (3) drive(0, 0, 0);
        settle();
        chk("fast_flash_blank", 64'(blank_out), 1);
        chk("lap_before_reset", 64'(lap_cnt), 2);
        nx_reset = 1;
        drive(0, 0, 0);
        settle();
        chk("midflash_reset_frame", frame_out, PAT_A);
        chk("midflash_reset_state", 64'(state_out), 0);
        chk("midflash_reset_blank", 64'(blank_out), 0);
        chk("midflash_reset_lap", 64'(lap_cnt), 0);
        chk("midflash_reset_busy", 64'(busy), 0);
        nx_reset = 0;

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) nx_speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) nx_flash = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)  nx_dir = ~nx_dir;
            nx_pat   = 1'($urandom_range(0, 1));
            nx_reset = ($urandom_range(0, 499) == 0);
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
        end
        nx_reset = 0;
        repeat (4) drive(0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge sys_clk_in);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
